lcd_rgb_rx: RTL and testbench

// - Receive end of the 16-bit RGB LCD Pmod interface (RGB565 + hsync/vsync/de) driven by the racing-the-beam tops.
// - Recovers pixel coordinates and measures frame geometry; declares lock after consecutive good frames.
// - Used for loopback self-check on the iCE40 board and as a bench monitor for 480x272 designs.
// - Sampled on the same clk_pix the transmitter uses (loopback or testbench); no CDC inside.

---
 rtl/lcd_rgb_rx.sv | 241 ++++++++++++++++++++++++
 tb/tb_lcd_rgb_rx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_rgb_rx.sv
// lcd_rgb_rx: receive end of the 16-bit RGB565 LCD Pmod link.
// Recovers pixel coordinates, measures frame geometry and declares lock
// after LOCK_FRAMES consecutive good frames. All logic runs on clk_pix.
// Optional feature macro: LCD_RX_CRC_EN adds frame_crc, a CRC-16-CCITT
// (poly 0x1021, init 0xFFFF, MSB first) over every de pixel of a frame.
module lcd_rgb_rx #(
  parameter int CORDW       = 10,
  parameter int H_RES       = 480,
  parameter int V_RES       = 272,
  parameter int LOCK_FRAMES = 2,
  parameter int SYNC_POL    = 0
) (
  input  logic             clk_pix,
  input  logic             rst_pix_n,
  input  logic             vga_hsync,
  input  logic             vga_vsync,
  input  logic             vga_de,
  input  logic [4:0]       vga_r,
  input  logic [5:0]       vga_g,
  input  logic [4:0]       vga_b,
  output logic             pix_valid,
  output logic [15:0]      pix_rgb,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             frame_done,
  output logic             frame_ok,
  output logic [CORDW-1:0] h_meas,
  output logic [CORDW-1:0] v_meas,
`ifdef LCD_RX_CRC_EN
  output logic [15:0]      frame_crc,
`endif
  output logic             locked
);

  localparam logic [CORDW-1:0] C_MAX  = {CORDW{1'b1}};
  localparam logic [CORDW-1:0] C_ZERO = {CORDW{1'b0}};
  localparam logic [CORDW-1:0] ONE    = CORDW'(1);
  localparam logic [CORDW-1:0] H_EXP  = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_EXP  = CORDW'(V_RES);
  localparam logic [4:0]       LOCK_N = 5'(LOCK_FRAMES);
  localparam logic             POL    = (SYNC_POL != 0);

  typedef enum logic [1:0] {SEARCH = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_t;

  state_t            state;
  logic [3:0]        gcnt;
  logic              s1_hs, s1_vs, s1_de, s2_vs, s2_de;
  logic [15:0]       s1_rgb;
  logic [CORDW-1:0]  h_work;
  logic              have_h, err, discard;

  logic              de_rise, de_fall, vs_rise;
  logic [CORDW-1:0]  line_w, sx_nx, sy_nx, h_nx, h_cl, v_cl;
  logic              have_nx, err_nx, disc_nx, err_cl, ok_cl, lock_nx;
  logic [4:0]        gcnt_inc;

  assign de_rise  = s1_de & ~s2_de;
  assign de_fall  = ~s1_de & s2_de;
  assign vs_rise  = s1_vs & ~s2_vs;
  assign line_w   = (sx == C_MAX) ? C_MAX : sx + ONE;
  assign gcnt_inc = {1'b0, gcnt} + 5'd1;
  assign ok_cl    = (h_cl == H_EXP) && (v_cl == V_EXP) && !err_cl;

  // Input pipe: stage 1 samples the pins (syncs normalised to 1 = active), stage 2 keeps the previous sample.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      s1_hs  <= 1'b0;
      s1_vs  <= 1'b0;
      s1_de  <= 1'b0;
      s1_rgb <= 16'h0000;
      s2_vs  <= 1'b0;
      s2_de  <= 1'b0;
    end else begin
      s1_hs  <= vga_hsync ^ ~POL;
      s1_vs  <= vga_vsync ^ ~POL;
      s1_de  <= vga_de;
      s1_rgb <= {vga_r, vga_g, vga_b};
      s2_vs  <= s1_vs;
      s2_de  <= s1_de;
    end
  end

  // Coordinate counters and per-frame working registers; the line end is settled before a frame closes.
  always_comb begin
    sx_nx   = sx;
    sy_nx   = sy;
    h_nx    = h_work;
    have_nx = have_h;
    err_nx  = err;
    disc_nx = discard;
    if (de_rise) begin
      sx_nx = C_ZERO;
    end else if (s1_de) begin
      if (sx == C_MAX) err_nx = 1'b1;
      else             sx_nx  = sx + ONE;
    end else begin
      sx_nx = sx;
    end
    if (de_fall) begin
      if (discard) begin
        disc_nx = 1'b0;
      end else begin
        if (!have_h) begin
          h_nx    = line_w;
          have_nx = 1'b1;
        end else if (line_w != h_work) begin
          err_nx = 1'b1;
        end else begin
          err_nx = err_nx;
        end
        if (sy == C_MAX) err_nx = 1'b1;
        else             sy_nx  = sy + ONE;
      end
    end else begin
      disc_nx = discard;
    end
    h_cl   = h_nx;
    v_cl   = sy_nx;
    err_cl = err_nx;
    // A line still active at the frame edge is dropped from the new frame.
    if (vs_rise) begin
      h_nx    = C_ZERO;
      have_nx = 1'b0;
      err_nx  = 1'b0;
      sy_nx   = C_ZERO;
      disc_nx = s1_de;
    end else begin
      disc_nx = disc_nx;
    end
    if (s1_de && (s1_hs || s1_vs)) err_nx = 1'b1;
    else                           err_nx = err_nx;
  end

  // Lock status as it will be after this cycle, so locked and pix_valid change together with frame_done.
  always_comb begin
    case (state)
      LOCKED:  lock_nx = !(vs_rise && !ok_cl);
      TRACK:   lock_nx = vs_rise && ok_cl && (gcnt_inc >= LOCK_N);
      default: lock_nx = 1'b0;
    endcase
  end

  // Lock FSM, frame close and all registered outputs.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state      <= SEARCH;
      gcnt       <= 4'd0;
      sx         <= C_ZERO;
      sy         <= C_ZERO;
      h_work     <= C_ZERO;
      have_h     <= 1'b0;
      err        <= 1'b0;
      discard    <= 1'b0;
      pix_valid  <= 1'b0;
      pix_rgb    <= 16'h0000;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      h_meas     <= C_ZERO;
      v_meas     <= C_ZERO;
      locked     <= 1'b0;
    end else begin
      sx         <= sx_nx;
      sy         <= sy_nx;
      h_work     <= h_nx;
      have_h     <= have_nx;
      err        <= err_nx;
      discard    <= disc_nx;
      locked     <= lock_nx;
      pix_valid  <= s1_de & lock_nx;
      pix_rgb    <= (s1_de & lock_nx) ? s1_rgb : 16'h0000;
      frame_done <= 1'b0;
      case (state)
        SEARCH: begin
          if (vs_rise) begin
            state <= TRACK;
            gcnt  <= 4'd0;
          end
        end
        TRACK: begin
          if (vs_rise) begin
            frame_done <= 1'b1;
            frame_ok   <= ok_cl;
            h_meas     <= h_cl;
            v_meas     <= v_cl;
            if (ok_cl) begin
              gcnt <= gcnt + 4'd1;
              if (gcnt_inc >= LOCK_N) state <= LOCKED;
            end else begin
              gcnt <= 4'd0;
            end
          end
        end
        LOCKED: begin
          if (vs_rise) begin
            frame_done <= 1'b1;
            frame_ok   <= ok_cl;
            h_meas     <= h_cl;
            v_meas     <= v_cl;
            if (!ok_cl) begin
              state <= TRACK;
              gcnt  <= 4'd0;
            end
          end
        end
        default: begin
          state <= SEARCH;
          gcnt  <= 4'd0;
        end
      endcase
    end
  end

`ifdef LCD_RX_CRC_EN
  logic [15:0] crc_acc;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  // Frame CRC: accumulate every de pixel, publish and restart at each frame edge.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      crc_acc   <= 16'hFFFF;
      frame_crc <= 16'h0000;
    end else begin
      if (vs_rise) begin
        if (state != SEARCH) frame_crc <= crc_acc;
        crc_acc <= s1_de ? crc16_step(16'hFFFF, s1_rgb) : 16'hFFFF;
      end else if (s1_de) begin
        crc_acc <= crc16_step(crc_acc, s1_rgb);
      end
    end
  end
`endif

endmodule

// File: tb/tb_lcd_rgb_rx.sv
// Self-checking bench for lcd_rgb_rx with a frame-level reference model.
// Uses a reduced 24x10 geometry to keep frames short.
module tb_lcd_rgb_rx;
  localparam int CORDW  = 10;
  localparam int H_T    = 24;
  localparam int V_T    = 10;
  localparam int LOCK_T = 2;

  logic clk_pix = 1'b0;
  logic rst_pix_n = 1'b1;
  logic vga_hsync = 1'b1, vga_vsync = 1'b1, vga_de = 1'b0;
  logic [4:0] vga_r = 5'd0, vga_b = 5'd0;
  logic [5:0] vga_g = 6'd0;
  logic pix_valid, frame_done, frame_ok, locked;
  logic [15:0] pix_rgb;
  logic [CORDW-1:0] sx, sy, h_meas, v_meas;
`ifdef LCD_RX_CRC_EN
  logic [15:0] frame_crc;
  logic [15:0] crc_a;
`endif

  always #5 clk_pix = ~clk_pix;

  lcd_rgb_rx #(.CORDW(CORDW), .H_RES(H_T), .V_RES(V_T), .LOCK_FRAMES(LOCK_T), .SYNC_POL(0)) dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .pix_valid(pix_valid), .pix_rgb(pix_rgb), .sx(sx), .sy(sy),
    .frame_done(frame_done), .frame_ok(frame_ok), .h_meas(h_meas), .v_meas(v_meas),
`ifdef LCD_RX_CRC_EN
    .frame_crc(frame_crc),
`endif
    .locked(locked)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;
  int nd_save = 0;
  logic [15:0] seen_rgb = 16'h0000;

  typedef struct {
    bit de, done, ok, lk, xy;
    logic [15:0] rgb, crc;
    int x, y, h, v;
  } exp_t;
  exp_t pipe0, pipe1;

  // Reference model state: widths of the lines seen in the current frame.
  int m_w[$];
  bit m_err, m_search, m_locked, c_done, c_ok;
  int m_gcnt, m_h, m_v, m_y;
  logic [15:0] m_crc_acc, m_crc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    logic [16:0] t;
    r = c;
    for (int i = 0; i < 16; i++) begin
      t = {r, 1'b0};
      if (r[15] != d[15 - i]) t[15:0] = t[15:0] ^ 16'h1021;
      r = t[15:0];
    end
    return r;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.de = 0; e.done = 0; e.ok = 0; e.lk = 0; e.xy = 0;
    e.rgb = 16'h0; e.crc = 16'h0; e.x = 0; e.y = 0; e.h = 0; e.v = 0;
    return e;
  endfunction

  task automatic model_reset();
    m_w.delete();
    m_err = 0; m_search = 1; m_locked = 0; m_gcnt = 0;
    m_h = 0; m_v = 0; m_y = 0; m_crc_acc = 16'hFFFF; m_crc = 16'h0000;
  endtask

  // Frame closes at the vsync assertion: judge the whole frame from its line list.
  task automatic model_close();
    int h;
    bit same;
    if (m_search) begin
      m_search = 0;
      m_gcnt = 0;
    end else begin
      h = (m_w.size() > 0) ? m_w[0] : 0;
      same = 1;
      foreach (m_w[i]) if (m_w[i] != h) same = 0;
      c_ok = (h == H_T) && (m_w.size() == V_T) && same && !m_err;
      c_done = 1;
      m_h = h;
      m_v = m_w.size();
      m_crc = m_crc_acc;
      if (m_locked) begin
        if (!c_ok) begin m_locked = 0; m_gcnt = 0; end
      end else if (c_ok) begin
        m_gcnt++;
        if (m_gcnt >= LOCK_T) m_locked = 1;
      end else begin
        m_gcnt = 0;
      end
    end
    m_w.delete(); m_err = 0; m_y = 0; m_crc_acc = 16'hFFFF;
  endtask

  task automatic check_out(input exp_t e);
    chk("pix_valid", 32'(pix_valid), 32'(e.de));
    chk("frame_done", 32'(frame_done), 32'(e.done));
    chk("locked", 32'(locked), 32'(e.lk));
    chk("h_meas", 32'(h_meas), e.h);
    chk("v_meas", 32'(v_meas), e.v);
    if (e.done) begin
      chk("frame_ok", 32'(frame_ok), 32'(e.ok));
`ifdef LCD_RX_CRC_EN
      chk("frame_crc", 32'(frame_crc), 32'(e.crc));
`endif
    end
    if (e.de) chk("pix_rgb", 32'(pix_rgb), 32'(e.rgb));
    if (e.xy) begin
      chk("sx", 32'(sx), e.x);
      chk("sy", 32'(sy), e.y);
    end
    if (frame_done) n_done++;
    if (pix_valid && sx == 10'd5 && sy == 10'd3) seen_rgb = pix_rgb;
  endtask

  // One pixel-clock step: check outputs due from two steps ago, then drive and model this cycle.
  task automatic step(input bit de, input bit hs, input bit vs, input logic [15:0] px,
                      input int x, input int y, input bit close);
    exp_t e;
    @(negedge clk_pix);
    check_out(pipe0);
    pipe0 = pipe1;
    vga_de = de;
    vga_hsync = ~hs;
    vga_vsync = ~vs;
    {vga_r, vga_g, vga_b} = px;
    c_done = 0;
    c_ok = 0;
    if (close) model_close();
    if (de && (hs || vs)) m_err = 1;
    if (de) m_crc_acc = crc_model(m_crc_acc, px);
    e.de = de && m_locked; e.done = c_done; e.ok = c_ok; e.lk = m_locked;
    e.xy = de && !m_search; e.rgb = px; e.crc = m_crc;
    e.x = x; e.y = y; e.h = m_h; e.v = m_v;
    pipe1 = e;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 16'($urandom), 0, 0, 0);
  endtask

  task automatic line(input int w, input int solid);
    logic [15:0] px;
    for (int x = 0; x < w; x++) begin
      if (solid == 0) px = (m_y == 3 && x == 5) ? 16'h07E0 : 16'($urandom);
      else            px = (solid == 2 && m_y == 2 && x == 7) ? 16'hFFFE : 16'hFFFF;
      step(1, 0, 0, px, x, m_y, 0);
    end
    m_w.push_back(w);
    m_y++;
    idle($urandom_range(1, 3));
    for (int i = 0; i < 2; i++) step(0, 1, 0, 16'($urandom), 0, 0, 0);
    idle($urandom_range(1, 3));
  endtask

  task automatic drive_frame(input int bad_line, input int bad_w, input bit vs_de, input int solid);
    for (int l = 0; l < V_T; l++) line((l == bad_line) ? bad_w : H_T, solid);
    idle(2);
    step(0, 0, 1, 16'($urandom), 0, 0, 1);
    step(0, 0, 1, 16'($urandom), 0, 0, 0);
    if (vs_de) begin
      for (int x = 0; x < 2; x++) step(1, 0, 1, 16'($urandom), x, m_y, 0);
      m_w.push_back(2);
      m_y++;
      step(0, 0, 1, 16'($urandom), 0, 0, 0);
    end
    step(0, 0, 1, 16'($urandom), 0, 0, 0);
    idle(2);
  endtask

  task automatic do_reset();
    @(negedge clk_pix);
    rst_pix_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      {vga_hsync, vga_vsync, vga_de} = 3'($urandom);
      {vga_r, vga_g, vga_b} = 16'($urandom);
      @(negedge clk_pix);
      chk("rst_pix_valid", 32'(pix_valid), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_frame_ok", 32'(frame_ok), 32'd0);
      chk("rst_pix_rgb", 32'(pix_rgb), 32'd0);
      chk("rst_coord", 32'({sx, sy}), 32'd0);
      chk("rst_meas", 32'({h_meas, v_meas}), 32'd0);
`ifdef LCD_RX_CRC_EN
      chk("rst_frame_crc", 32'(frame_crc), 32'd0);
`endif
    end
    vga_de = 1'b0; vga_hsync = 1'b1; vga_vsync = 1'b1;
    model_reset();
    pipe0 = zero_exp();
    pipe1 = zero_exp();
    rst_pix_n = 1'b1;
  endtask

  initial begin
    model_reset();
    pipe0 = zero_exp();
    pipe1 = zero_exp();
    do_reset();
    idle(5);
    // First frame only supplies the first vsync edge.
    drive_frame(-1, 0, 0, 0);
    chk("lit_no_done_search", 32'(n_done), 32'd0);
    chk("lit_unlocked_1", 32'(locked), 32'd0);
    drive_frame(-1, 0, 0, 0);
    chk("lit_unlocked_2", 32'(locked), 32'd0);
    drive_frame(-1, 0, 0, 0);
    chk("lit_done_cnt", 32'(n_done), 32'd2);
    chk("lit_locked_3", 32'(locked), 32'd1);
    chk("lit_h_meas", 32'(h_meas), 32'd24);
    chk("lit_v_meas", 32'(v_meas), 32'd10);
    chk("lit_frame_ok", 32'(frame_ok), 32'd1);
    // Short line in the middle of the frame breaks lock.
    drive_frame(5, H_T - 1, 0, 0);
    chk("lit_bad_ok", 32'(frame_ok), 32'd0);
    chk("lit_bad_locked", 32'(locked), 32'd0);
    chk("lit_bad_h", 32'(h_meas), 32'd24);
    drive_frame(-1, 0, 0, 0);
    chk("lit_relock_1", 32'(locked), 32'd0);
    drive_frame(-1, 0, 0, 0);
    chk("lit_relock_2", 32'(locked), 32'd1);
    // Locked frame carrying 0x07E0 at (5,3), then de during vsync.
    drive_frame(-1, 0, 1, 0);
    chk("lit_pix_5_3", 32'(seen_rgb), 32'h07E0);
    chk("lit_locked_g", 32'(locked), 32'd1);
    drive_frame(-1, 0, 0, 0);
    chk("lit_syncerr_ok", 32'(frame_ok), 32'd0);
    chk("lit_syncerr_v", 32'(v_meas), 32'd11);
    chk("lit_syncerr_lock", 32'(locked), 32'd0);
    // Reset in the middle of a frame.
    line(H_T, 0);
    line(H_T, 0);
    line(H_T, 0);
    do_reset();
    nd_save = n_done;
    drive_frame(-1, 0, 0, 0);
    chk("lit_post_rst_nodone", 32'(n_done - nd_save), 32'd0);
    drive_frame(-1, 0, 0, 0);
    chk("lit_post_rst_done", 32'(n_done - nd_save), 32'd1);
    chk("lit_post_rst_ok", 32'(frame_ok), 32'd1);
    chk("lit_post_rst_lock", 32'(locked), 32'd0);
`ifdef LCD_RX_CRC_EN
    drive_frame(-1, 0, 0, 1);
    crc_a = frame_crc;
    drive_frame(-1, 0, 0, 2);
    chk("lit_crc_differs", 32'(crc_a != frame_crc), 32'd1);
`endif
    idle(3);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
